nebula_walking_io: RTL and testbench
====================================

Name: nebula_walking_io

Overview:
- User-project block in the Nebula II user area of the Caravel wrapper. It drives the 38 user GPIO lines.
- On enable it presents a 16-bit start signature, then walks a single one across the user-owned GPIO bits, then clears all outputs.
- Chip-level firmware tests use it to prove every user GPIO path in order.

Parameters:
- SIG_CYCLES, 64, clock cycles the start signature is held (must be ≥1).
- STEP_CYCLES, 32, clock cycles each walking-one pattern is held (must be ≥1).
- SIGNATURE, 16'hAB60, value driven on io_out[31:16] during the signature phase.

Ports:
- clk  input  1  system clock (user-area Wishbone clock)
- nrst  input  1  reset, asynchronous assert, active-low
- en  input  1  run enable; level-sensitive
- io_out  output  38  GPIO output values
- io_oeb  output  38  GPIO output-enable-bar (0 = drive)
- busy  output  1  high in SIGNATURE or WALK
- done  output  1  high in DONE

Behaviour:
- One clock domain. Reset is asynchronous and active-low. All state and outputs are registered (outputs change only on posedge clk, or on reset).
- Reset values:
  - state = IDLE
  - io_out = 0
  - io_oeb = all 1
  - busy = 0, done = 0
  - counters = 0
- io_oeb:
  - bits 1–3 always 1; they are management/SPI-owned and never driven.
  - Bits 0 and 4–37 are 0 whenever state ≠ IDLE, else 1.
- io_out bits 1–3 are always 0.
- States: IDLE, SIGNATURE, WALK, DONE.
- IDLE:
  - io_out = 0.
  - en=1 sampled → SIGNATURE next cycle.
- SIGNATURE:
  - io_out[31:16] = SIGNATURE; all other bits 0.
  - Held exactly SIG_CYCLES cycles, then → WALK with position = 0.
- WALK:
  - io_out = one-hot at bit `position`; the position sequence is 0, 4, 5, 6, …, 37 (35 patterns; bits 1–3 skipped).
  - Each pattern is held exactly STEP_CYCLES cycles.
  - After bit 37 has been held its full time → DONE.
  - The position register is 6 bits; the 0→4 jump is explicit and there is no wrap-around.
- DONE:
  - io_out = 0 (all-zero pattern, the final expected GPIO state); done = 1.
  - Remains in DONE while en=1.
  - en=0 → IDLE next cycle; a new run requires en to be high again after IDLE.
- en deasserted in SIGNATURE or WALK (abort): next cycle → IDLE, io_out = 0, io_oeb released, counters cleared. A later en restarts from SIGNATURE.
- en=1 held continuously never re-triggers a run from DONE.
- nrst asserted at any time: immediate return to reset values.
- Cycle counter is 16 bits; it reloads to 0 on every state or position change.

Test Plan:
- Reset: nrst=0 mid-run → io_out=0, io_oeb=38'h3F_FFFF_FFFF, busy=0, done=0 immediately (without waiting for a clock edge).
- Signature: SIG_CYCLES=4, en 0→1 → one cycle later io_out[31:16]=16'hAB60 with other bits 0, io_oeb=38'h0E, busy=1; held exactly 4 cycles.
- Walk order: STEP_CYCLES=2 → io_out sequence 38'h1, 38'h10, 38'h20, …, 38'h20_0000_0000, each held 2 cycles; then 38'h0 with done=1. Check every pattern equals the expected one-hot exactly.
- Abort: en dropped while io_out=38'h100 → next cycle io_out=0, state IDLE; re-raise en → signature 16'hAB60 appears again.
- Done hold/rearm: en held high after DONE → io_out stays 0, done=1 for ≥100 cycles; en=0 → done=0 next cycle; en=1 → new run.
- Bits 1–3: throughout a full run, io_out[3:1]=0 and io_oeb[3:1]=3'b111.

Source files
------------

// File: rtl/nebula_walking_io.sv
// GPIO path prover for the Caravel user area: shows a start signature, walks a
// single one across every user-owned GPIO (skipping management bits 1-3), then parks at zero.
module nebula_walking_io #(
    parameter int          SIG_CYCLES  = 64,
    parameter int          STEP_CYCLES = 32,
    parameter logic [15:0] SIGNATURE   = 16'hAB60
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        en,
    output logic [37:0] io_out,
    output logic [37:0] io_oeb,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        stIdle,
        stSignature,
        stWalk,
        stDone
    } state_t;

    localparam logic [37:0] MgmtMask = 38'h0E;
    localparam logic [15:0] SigLast  = 16'(SIG_CYCLES - 1);
    localparam logic [15:0] StepLast = 16'(STEP_CYCLES - 1);
    localparam logic [5:0]  LastPos  = 6'd37;

    state_t      state_q, state_d;
    logic [5:0]  pos_q, pos_d;
    logic [15:0] cnt_q, cnt_d;
    logic [37:0] ioOut_q, ioOut_d;
    logic [37:0] ioOeb_q, ioOeb_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        cnt_d   = cnt_q + 16'd1;

        case (state_q)
            stIdle: begin
                cnt_d = '0;
                pos_d = '0;
                if (en) state_d = stSignature;
            end
            stSignature: begin
                if (!en) begin
                    state_d = stIdle;
                    cnt_d   = '0;
                    pos_d   = '0;
                end else if (cnt_q == SigLast) begin
                    state_d = stWalk;
                    cnt_d   = '0;
                    pos_d   = '0;
                end
            end
            stWalk: begin
                if (!en) begin
                    state_d = stIdle;
                    cnt_d   = '0;
                    pos_d   = '0;
                end else if (cnt_q == StepLast) begin
                    cnt_d = '0;
                    // Position 0 jumps straight to 4 so bits 1-3 are never visited.
                    if (pos_q == LastPos) begin
                        state_d = stDone;
                        pos_d   = '0;
                    end else if (pos_q == 6'd0) begin
                        pos_d = 6'd4;
                    end else begin
                        pos_d = pos_q + 6'd1;
                    end
                end
            end
            stDone: begin
                cnt_d = '0;
                pos_d = '0;
                if (!en) state_d = stIdle;
            end
            default: begin
                state_d = stIdle;
                cnt_d   = '0;
                pos_d   = '0;
            end
        endcase
    end

    // Outputs are derived from the next state so they register in step with it.
    always_comb begin
        ioOut_d = '0;
        ioOeb_d = '1;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_d)
            stSignature: begin
                ioOut_d = {6'b0, SIGNATURE, 16'b0};
                ioOeb_d = MgmtMask;
                busy_d  = 1'b1;
            end
            stWalk: begin
                ioOut_d = 38'd1 << pos_d;
                ioOeb_d = MgmtMask;
                busy_d  = 1'b1;
            end
            stDone: begin
                ioOeb_d = MgmtMask;
                done_d  = 1'b1;
            end
            default: begin
                ioOut_d = '0;
                ioOeb_d = '1;
            end
        endcase

        ioOut_d = ioOut_d & ~MgmtMask;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= stIdle;
            pos_q   <= '0;
            cnt_q   <= '0;
            ioOut_q <= '0;
            ioOeb_q <= '1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            cnt_q   <= cnt_d;
            ioOut_q <= ioOut_d;
            ioOeb_q <= ioOeb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign io_out = ioOut_q;
    assign io_oeb = ioOeb_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_nebula_walking_io.sv
// Directed bench for nebula_walking_io with short signature and step times.
module tb_nebula_walking_io;

    localparam logic [37:0] SigPattern = 38'h00_AB60_0000;
    localparam logic [37:0] OebActive  = 38'h00_0000_000E;
    localparam logic [37:0] OebIdle    = 38'h3F_FFFF_FFFF;

    logic        clk;
    logic        nrst;
    logic        en;
    logic [37:0] io_out;
    logic [37:0] io_oeb;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    nebula_walking_io #(
        .SIG_CYCLES (4),
        .STEP_CYCLES(2),
        .SIGNATURE  (16'hAB60)
    ) dut (
        .clk   (clk),
        .nrst  (nrst),
        .en    (en),
        .io_out(io_out),
        .io_oeb(io_oeb),
        .busy  (busy),
        .done  (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic enVal);
        en = enVal;
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkSignatureCycle(input string tag);
        checkOutput({tag, "_out"}, 64'(io_out), 64'(SigPattern));
        checkOutput({tag, "_oeb"}, 64'(io_oeb), 64'(OebActive));
        checkOutput({tag, "_busy"}, 64'(busy), 64'd1);
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_out"}, 64'(io_out), 64'd0);
        checkOutput({tag, "_oeb"}, 64'(io_oeb), 64'(OebIdle));
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "_done"}, 64'(done), 64'd0);
    endtask

    initial begin
        int positions[35];
        logic [37:0] expOut;
        bit found;

        positions[0] = 0;
        for (int k = 1; k < 35; k++) positions[k] = k + 3;

        nrst = 1'b1;
        en   = 1'b0;
        #3 nrst = 1'b0;
        #1;
        checkIdle("reset");

        repeat (2) @(posedge clk);
        #1 nrst = 1'b1;
        tick();
        checkIdle("idle_after_reset");

        applyStimulus(1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            checkSignatureCycle("sig");
            tick();
        end

        for (int p = 0; p < 35; p++) begin
            expOut = 38'd1 << positions[p];
            for (int c = 0; c < 2; c++) begin
                checkOutput($sformatf("walk_p%0d_c%0d", positions[p], c), 64'(io_out), 64'(expOut));
                checkOutput("walk_oeb", 64'(io_oeb), 64'(OebActive));
                checkOutput("walk_out_mgmt", 64'(io_out[3:1]), 64'd0);
                tick();
            end
        end

        for (int i = 0; i < 100; i++) begin
            checkOutput("done_out", 64'(io_out), 64'd0);
            checkOutput("done_flag", 64'(done), 64'd1);
            checkOutput("done_busy", 64'(busy), 64'd0);
            checkOutput("done_oeb", 64'(io_oeb), 64'(OebActive));
            tick();
        end

        applyStimulus(1'b0);
        tick();
        checkIdle("rearm_idle");

        applyStimulus(1'b1);
        tick();
        checkSignatureCycle("rerun_sig");

        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (io_out == 38'h100) found = 1'b1;
            else tick();
        end
        checkOutput("reach_bit8", 64'(found), 64'd1);

        applyStimulus(1'b0);
        tick();
        checkIdle("abort");

        applyStimulus(1'b1);
        tick();
        checkSignatureCycle("abort_restart_sig");

        repeat (7) tick();
        checkOutput("pre_reset_busy", 64'(busy), 64'd1);
        #2 nrst = 1'b0;
        #1;
        checkIdle("async_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
